// File: rtl/i2c_target_if.sv
// Host-side handshake of the I2C target: read payload in, write command out, bus status.
// The open-drain pins stay on the target itself so the tristate lives at the pad boundary.
interface i2c_target_if;
    logic [47:0] Tx_Data;
    logic        Tx_Load;
    logic [7:0]  Cmd_Byte;
    logic        Cmd_Valid;
    logic        Busy;

    modport slave (
        input  Tx_Data,
        output Tx_Load,
        output Cmd_Byte,
        output Cmd_Valid,
        output Busy
    );

    modport master (
        output Tx_Data,
        input  Tx_Load,
        input  Cmd_Byte,
        input  Cmd_Valid,
        input  Busy
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target with a fixed 7-bit address: write bytes surface on Cmd_Byte,
// reads stream a 6-byte snapshot of Tx_Data. SDA is open-drain (0 or Z only).
module i2c_target #(
    parameter logic [6:0]  Target_Addr = 7'h44,
    parameter int unsigned Sync_Stages = 2
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        Scl_Data,
    inout  wire         Sda_Data,
    i2c_target_if.slave host
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [Sync_Stages-1:0] scl_sync_q, scl_sync_d;
    logic [Sync_Stages-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [2:0]             byte_cnt_q, byte_cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [47:0]            tx_buf_q, tx_buf_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   busy_q, busy_d;
    logic [7:0]             cmd_byte_q, cmd_byte_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   tx_load_q, tx_load_d;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = scl_sync_q[Sync_Stages-1];
    assign sda_s     = sda_sync_q[Sync_Stages-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 3'd0;
            shift_q     <= 7'd0;
            tx_buf_q    <= 48'd0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_byte_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
            tx_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            tx_buf_q    <= tx_buf_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            tx_load_q   <= tx_load_d;
        end
    end

    // SDA drive is only ever updated on a detected SCL fall, so it settles while SCL is low.
    always_comb begin
        scl_sync_d  = {scl_sync_q[Sync_Stages-2:0], Scl_Data};
        sda_sync_d  = {sda_sync_q[Sync_Stages-2:0], Sda_Data};
        scl_prev_d  = scl_s;
        sda_prev_d  = sda_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        tx_buf_d    = tx_buf_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        tx_load_d   = 1'b0;

        if (start_det) begin
            state_d    = ADDR;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 3'd0;
            busy_d     = 1'b1;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = (shift_q == Target_Addr) ? ADDR_ACK : WAIT_STOP;
                        end
                    end
                end
                // First fall after the 8th bit starts the ACK; the second ends it.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (!shift_q[0]) begin
                            sda_oe_d = 1'b0;
                            state_d  = RX_BYTE;
                        end else begin
                            tx_buf_d  = host.Tx_Data;
                            tx_load_d = 1'b1;
                            sda_oe_d  = ~host.Tx_Data[47];
                            state_d   = TX_BYTE;
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            cmd_byte_d  = {shift_q, sda_s};
                            cmd_valid_d = 1'b1;
                            state_d     = RX_ACK;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = RX_BYTE;
                        end
                    end
                end
                TX_BYTE: begin
                    if (scl_fall) begin
                        tx_buf_d  = {tx_buf_q[46:0], 1'b1};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = TX_ACK;
                        end else begin
                            sda_oe_d = ~tx_buf_q[46];
                        end
                    end
                end
                // Only an ACK with bytes left keeps us here until the falling edge.
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s || (byte_cnt_q == 3'd5)) begin
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        sda_oe_d   = ~tx_buf_q[47];
                        state_d    = TX_BYTE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        host.Tx_Load   = tx_load_q;
        host.Cmd_Byte  = cmd_byte_q;
        host.Cmd_Valid = cmd_valid_q;
        host.Busy      = busy_q;
    end

    assign Sda_Data = sda_oe_q ? 1'b0 : 1'bz;
endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter Target_Addr, default 7'h44, 7-bit I2C address the block answers to.
REQ-002 Parameter Sync_Stages, default 2, synchronizer flops on Scl_Data and Sda_Data inputs (minimum 2).
REQ-003 clk  input  1  system clock; all logic on posedge; at least 16x the SCL frequency.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 Scl_Data  input  1  I2C clock line as seen at the pin; the target never drives SCL.
REQ-006 Sda_Data  inout  1  I2C data line, open-drain; driven only 1'b0 or 1'bZ, never 1'b1.
REQ-007 Tx_Data  input  48  read payload {T_MSB,T_LSB,T_CRC,H_MSB,H_LSB,H_CRC}, byte 0 at [47:40].
REQ-008 Tx_Load  output  1  one-cycle pulse when Tx_Data is captured into the shift buffer.
REQ-009 Cmd_Byte  output  8  last data byte received in a write transfer.
REQ-010 Cmd_Valid  output  1  one-cycle pulse when Cmd_Byte updates.
REQ-011 Busy  output  1  high from a detected START until the next detected STOP.

Function
REQ-012 Scl_Data and Sda_Data SHALL pass through Sync_Stages flops; all edge/condition detection uses synchronized values plus one delayed copy.
REQ-013 START = synchronized SDA 1->0 while synchronized SCL high; STOP = SDA 0->1 while SCL high; both take priority over every other transition.
REQ-014 START (incl. repeated START) from any state SHALL release SDA, clear bit and byte counters, enter ADDR; STOP from any state SHALL release SDA and enter IDLE.
REQ-015 States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-016 Data SHALL be sampled on the cycle a synchronized SCL rising edge is detected, MSB first, 3-bit bit counter.
REQ-017 SDA drive changes SHALL occur only on the cycle after a synchronized SCL falling edge is detected, never while SCL is high.
REQ-018 ADDR: after 8 bits, if [7:1]==Target_Addr go to ADDR_ACK and pull SDA low for the 9th clock; else go to WAIT_STOP with SDA released.
REQ-019 ADDR_ACK: on the 9th SCL falling edge, R/W=0 -> RX_BYTE with SDA released; R/W=1 -> capture Tx_Data, pulse Tx_Load, drive bit 47 and enter TX_BYTE.
REQ-020 RX_BYTE: after 8 bits update Cmd_Byte, pulse Cmd_Valid on the same cycle, enter RX_ACK and pull SDA low for the 9th clock; on its falling edge release SDA and return to RX_BYTE (unlimited bytes).
REQ-021 TX_BYTE: drive 0 for a 0 bit, Z for a 1 bit; after the 8th falling edge release SDA and enter TX_ACK.
REQ-022 TX_ACK: sample SDA on the 9th rising edge; 0 (ACK) and byte counter <5 -> increment byte counter, present next byte MSB on the falling edge, TX_BYTE; 1 (NACK) -> WAIT_STOP.
REQ-023 ACK after byte 5 SHALL enter WAIT_STOP with SDA released (no wrap; master sees 0xFF on further reads).
REQ-024 Tx_Data changes after Tx_Load SHALL not affect the transfer in progress.
REQ-025 Busy SHALL be registered, asserting the cycle after START detection and clearing the cycle after STOP detection.

Reset
REQ-026 Rst SHALL force IDLE, SDA=Z, Busy=0, Cmd_Byte=8'h00, Cmd_Valid=0, Tx_Load=0, counters=0, synchronizer flops=1.
REQ-027 Rst asserted mid-transfer SHALL release SDA on the next clk edge; the block resumes only at the next START after Rst deasserts.

Verification
REQ-028 Write 0x88 then 0xFD, STOP -> ACK low on both 9th clocks, Cmd_Byte=0xFD, one Cmd_Valid pulse, Busy low after STOP.
REQ-029 Read 0x89, Tx_Data=48'h6666_93_8000_A2, master ACKs bytes 0-4, NACKs byte 5 -> bus reads 66 66 93 80 00 A2, one Tx_Load pulse.
REQ-030 Address 0x90 (target 0x45) -> SDA never driven low through STOP, no Cmd_Valid/Tx_Load.
REQ-031 Write 0xFD, repeated START, read 3 bytes with NACK on byte 2 -> Cmd_Valid once, then first 3 payload bytes, SDA released after NACK.
REQ-032 Rst asserted while driving a 0 bit in TX_BYTE -> SDA=Z next clk, all outputs at reset values, next valid read transfer completes normally.
REQ-033 Checker throughout: SDA never changes while synchronized SCL high except START/STOP from master; SDA never driven 1.
